subleq_cpu_card: RTL

- Execution card of the SUBLEQ machine: one `subleq a, b, c` per pass.
  - Steps: read three operand words, read both memory operands, write back `mem[b] - mem[a]`, then branch.
- Sits directly downstream of the clock card: consumes its `clk`; drives the shared address and data buses plus the control bus that memory cards decode.
- Every memory access is a request/acknowledge handshake, so slow memory cards insert wait states.

---
 rtl/subleq_cpu_card.sv | 119 +++++++++++
 1 files changed

// File: rtl/subleq_cpu_card.sv
// SUBLEQ execution card: runs one "subleq a, b, c" per pass over a request/acknowledge
// memory bus, with every bus output registered so memory cards see glitch-free signals.
module subleq_cpu_card #(
    parameter int DATAWIDTH = 16,
    parameter int CTRLWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic                 ack,
    output logic [DATAWIDTH-1:0] address,
    output logic [DATAWIDTH-1:0] data,
    output logic [CTRLWIDTH-1:0] ctrl
);

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        FETCH_C,
        LOAD_A,
        LOAD_B,
        STORE,
        HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   pc_q, pc_d;
    logic [DATAWIDTH-1:0]   opa_q, opa_d;
    logic [DATAWIDTH-1:0]   opb_q, opb_d;
    logic [DATAWIDTH-1:0]   opc_q, opc_d;
    logic [DATAWIDTH-1:0]   va_q, va_d;
    logic [DATAWIDTH-1:0]   res_q, res_d;
    logic [DATAWIDTH-1:0]   address_q, address_d;
    logic [DATAWIDTH-1:0]   data_q, data_d;
    logic [CTRLWIDTH-1:0]   ctrl_q, ctrl_d;
    logic                   done;
    logic                   branchTaken;

    // An access completes only while its request is actually on the bus, so the idle
    // cycle that follows reset cannot swallow an ack meant for the first fetch.
    assign done        = ack && (ctrl_q[0] || ctrl_q[1]);
    assign branchTaken = res_q[DATAWIDTH-1] || (res_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        va_d    = va_q;
        res_d   = res_q;

        if (done) begin
            case (state_q)
                FETCH_A: begin opa_d = data_in; state_d = FETCH_B; end
                FETCH_B: begin opb_d = data_in; state_d = FETCH_C; end
                FETCH_C: begin opc_d = data_in; state_d = LOAD_A;  end
                LOAD_A:  begin va_d  = data_in; state_d = LOAD_B;  end
                LOAD_B:  begin res_d = data_in - va_q; state_d = STORE; end
                STORE: begin
                    if (branchTaken) begin
                        pc_d    = opc_q;
                        state_d = opc_q[DATAWIDTH-1] ? HALT : FETCH_A;
                    end else begin
                        pc_d    = pc_q + DATAWIDTH'(3);
                        state_d = FETCH_A;
                    end
                end
                default: ;
            endcase
        end

        // Bus outputs are decoded from the state being entered and then registered.
        address_d = pc_d;
        data_d    = '0;
        ctrl_d    = '0;
        case (state_d)
            FETCH_A: ctrl_d[0] = 1'b1;
            FETCH_B: begin address_d = pc_d + DATAWIDTH'(1); ctrl_d[0] = 1'b1; end
            FETCH_C: begin address_d = pc_d + DATAWIDTH'(2); ctrl_d[0] = 1'b1; end
            LOAD_A:  begin address_d = opa_d; ctrl_d[0] = 1'b1; end
            LOAD_B:  begin address_d = opb_d; ctrl_d[0] = 1'b1; end
            STORE:   begin address_d = opb_d; data_d = res_d; ctrl_d[1] = 1'b1; end
            HALT:    ctrl_d[2] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_A;
            pc_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            opc_q     <= '0;
            va_q      <= '0;
            res_q     <= '0;
            address_q <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            opc_q     <= opc_d;
            va_q      <= va_d;
            res_q     <= res_d;
            address_q <= address_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign address = address_q;
    assign data    = data_q;
    assign ctrl    = ctrl_q;

endmodule
